mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/toast_mem_pkg.sv | 15 +
 rtl/sync_ram.sv | 30 +++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toast_mem_pkg.sv
// rtl/toast_mem_pkg.sv - shared FSM state encoding and MMIO address map for mem_responder
package toast_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [15:0] MMIO_BASE = 16'hFF00;
  localparam logic [15:0] LED_ADDR  = 16'hFFF0;
  localparam logic [15:0] SW_ADDR   = 16'hFFF1;

endpackage

// File: rtl/sync_ram.sv
// rtl/sync_ram.sv - single-port 16-bit RAM, depth 2^AW, registered read, write enable
module sync_ram #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [15:0] r_mem [0:DEPTH-1];
  logic [15:0] r_rdata;

  // Read data register only moves on a read, so it holds through the response phase.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding CPU memory responder: RAM, wait states, optional MMIO
// Optional LED/switch MMIO block is enabled by defining MMIO_EN.
module mem_responder
  import toast_mem_pkg::*;
#(
  parameter int RAM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  led_out,
  input  logic [9:0]  sw_in
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait_cnt;
  logic        r_write;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_err;
  logic        r_mmio_sel;
  logic [15:0] r_mmio_rdata;

  logic        w_accept;
  logic        w_ram_hit;
  logic        w_mmio_hit;
  logic        w_err;
  logic [15:0] w_mmio_rdata;
  logic        w_ram_we;
  logic        w_ram_re;
  logic [15:0] w_ram_rdata;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_ram_hit = (r_addr >> RAM_AW) == 16'd0;

`ifdef MMIO_EN
  logic [9:0] r_led;
  logic [9:0] r_sw_meta;
  logic [9:0] r_sw_sync;
  logic       w_led_hit;
  logic       w_sw_hit;

  assign w_mmio_hit   = r_addr >= MMIO_BASE;
  assign w_led_hit    = r_addr == LED_ADDR;
  assign w_sw_hit     = r_addr == SW_ADDR;
  // Inside the MMIO window only LED (r/w) and switch reads are legal; MMIO shadows RAM.
  assign w_err        = w_mmio_hit ? !(w_led_hit || (w_sw_hit && !r_write)) : !w_ram_hit;
  assign w_mmio_rdata = w_led_hit ? {6'd0, r_led} : {6'd0, r_sw_sync};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_led     <= 10'd0;
      r_sw_meta <= 10'd0;
      r_sw_sync <= 10'd0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
      if ((r_state == ACCESS) && r_write && w_led_hit) begin
        r_led <= r_wdata[9:0];
      end
    end
  end

  assign led_out = r_led;
`else
  logic w_unused_sw;

  assign w_mmio_hit   = 1'b0;
  assign w_err        = !w_ram_hit;
  assign w_mmio_rdata = 16'd0;
  assign led_out      = 10'd0;
  assign w_unused_sw  = ^sw_in;
`endif

  // Reset on the access edge must keep a pending store from landing in RAM.
  assign w_ram_we = (r_state == ACCESS) && r_write && !w_err && !w_mmio_hit && !reset;
  assign w_ram_re = (r_state == ACCESS) && !r_write && !w_mmio_hit;

  sync_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clock  (clock),
    .i_we   (w_ram_we),
    .i_re   (w_ram_re),
    .i_addr (r_addr[RAM_AW-1:0]),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (r_wait_cnt == 4'd0) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt   <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 16'd0;
      r_wdata      <= 16'd0;
      r_err        <= 1'b0;
      r_mmio_sel   <= 1'b0;
      r_mmio_rdata <= 16'd0;
    end else begin
      if (w_accept) begin
        r_write    <= req_write;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_wait_cnt <= WS_LOAD;
      end else if ((r_state == WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (r_state == ACCESS) begin
        r_err        <= w_err;
        r_mmio_sel   <= w_mmio_hit;
        r_mmio_rdata <= w_mmio_rdata;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = (resp_valid && !r_err && !r_write) ?
                      (r_mmio_sel ? r_mmio_rdata : w_ram_rdata) : 16'd0;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized check of mem_responder (0 and 3 wait states) against a transaction model
module tb_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [9:0]  led_out    [2];
  logic [9:0]  sw_in;

  mem_responder #(.RAM_AW(12), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .led_out(led_out[0]), .sw_in(sw_in)
  );

  mem_responder #(.RAM_AW(12), .WAIT_STATES(3)) u_dut3 (
    .clock(clock), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .led_out(led_out[1]), .sw_in(sw_in)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Transaction-level model: one outstanding request, counted in cycles since acceptance.
  bit          busy     [2];
  int          cnt      [2];
  bit          post_rst [2];
  logic        m_w      [2];
  logic [15:0] m_a      [2];
  logic [15:0] m_wd     [2];
  logic [16:0] m_res    [2];
  logic [15:0] mdl_mem  [2][4096];
  logic [9:0]  mdl_led  [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic void chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, d, act, exp, $time);
    end
  endfunction

  function automatic logic [16:0] mdl_eval(input int d, input logic w, input logic [15:0] a);
    logic [16:0] r;
    r = {1'b1, 16'd0};
`ifdef MMIO_EN
    if (a >= 16'hFF00) begin
      if (a == 16'hFFF0)            r = {1'b0, w ? 16'd0 : {6'd0, mdl_led[d]}};
      else if (a == 16'hFFF1 && !w) r = {1'b0, {6'd0, sw_in}};
    end else
`endif
    if (a < 16'd4096) r = {1'b0, w ? 16'd0 : mdl_mem[d][a[11:0]]};
    return r;
  endfunction

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        busy[d]     <= 1'b0;
        cnt[d]      <= 0;
        mdl_led[d]  <= 10'd0;
        post_rst[d] <= 1'b1;
      end else if (!busy[d]) begin
        if (req_valid[d]) begin
          busy[d]     <= 1'b1;
          cnt[d]      <= 0;
          post_rst[d] <= 1'b0;
          m_w[d]      <= req_write[d];
          m_a[d]      <= req_addr[d];
          m_wd[d]     <= req_wdata[d];
          m_res[d]    <= mdl_eval(d, req_write[d], req_addr[d]);
        end
      end else begin
        if (cnt[d] == ws_of(d) && m_w[d] && !m_res[d][16]) begin
          if (m_a[d] >= 16'hFF00) mdl_led[d] <= m_wd[d][9:0];
          else                    mdl_mem[d][m_a[d][11:0]] <= m_wd[d];
        end
        if (cnt[d] >= ws_of(d) + 1 && resp_ready[d]) busy[d] <= 1'b0;
        else                                         cnt[d]  <= cnt[d] + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("req_ready", d, req_ready[d], !busy[d]);
        chk("resp_valid", d, resp_valid[d], busy[d] && (cnt[d] >= ws_of(d) + 1));
        if (busy[d] && (cnt[d] >= ws_of(d) + 1)) begin
          chk("resp_rdata", d, resp_rdata[d], m_res[d][15:0]);
          chk("resp_err", d, resp_err[d], m_res[d][16]);
        end
        if (post_rst[d]) begin
          chk("reset_rdata", d, resp_rdata[d], 16'd0);
          chk("reset_err", d, resp_err[d], 1'b0);
        end
`ifdef MMIO_EN
        chk("led_out", d, led_out[d], mdl_led[d]);
`else
        chk("led_out", d, led_out[d], 10'd0);
`endif
      end
    end
  end

  task automatic txn(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd,
                     input int hold, input bit keep, input bit early,
                     output logic [15:0] rd, output logic er, output int lat);
    int g;
    g = 0;
    while (busy[d] && g < 100) begin @(negedge clock); g++; end
    @(negedge clock);
    req_valid[d]  = 1'b1;
    req_write[d]  = w;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    resp_ready[d] = early;
    @(posedge clock); #1;
    if (!keep) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'($urandom);
      req_addr[d]  = 16'($urandom);
      req_wdata[d] = 16'($urandom);
    end
    lat = 0;
    while (!resp_valid[d] && lat < 40) begin @(negedge clock); lat++; end
    rd = resp_rdata[d];
    er = resp_err[d];
    if (!early) repeat (hold) @(negedge clock);
    resp_ready[d] = 1'b1;
    @(posedge clock); #1;
    resp_ready[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int g;
    g = 0;
    resp_ready[d] = 1'b1;
    while (busy[d] && g < 60) begin @(negedge clock); g++; end
    resp_ready[d] = 1'b0;
  endtask

  task automatic rst_in_access(input int d);
    @(negedge clock);
    req_valid[d] = 1'b1;
    req_write[d] = 1'b1;
    req_addr[d]  = 16'h0005;
    req_wdata[d] = 16'hBEEF;
    @(posedge clock); #1;
    req_valid[d] = 1'b0;
    repeat (ws_of(d)) begin @(posedge clock); #1; end
    rst[d] = 1'b1;
    @(posedge clock); #1;
    rst[d] = 1'b0;
    chk("rst_access_valid", d, resp_valid[d], 1'b0);
    chk("rst_access_ready", d, req_ready[d], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          sel;
    logic [15:0] a;
    logic        w;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = 16'd0; req_wdata[d] = 16'd0; resp_ready[d] = 1'b0;
    end
    sw_in = 10'd0;
    repeat (3) @(posedge clock);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    chk("reset_ready_lit", 0, req_ready[0], 1'b1);
    chk("reset_led_lit", 1, led_out[1], 10'd0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) begin
        txn(d, 1'b1, 16'(i), (i == 0) ? 16'hA5A5 : (i == 5) ? 16'h0505 : 16'($urandom),
            0, 1'b0, 1'b0, rd, er, lat);
      end
      txn(d, 1'b1, 16'h0FFF, 16'h7E57, 0, 1'b0, 1'b0, rd, er, lat);
    end

    txn(0, 1'b1, 16'h0010, 16'h1234, 0, 1'b0, 1'b0, rd, er, lat);
    chk("wr_lat_ws0", 0, lat, 2);
    chk("wr_err", 0, er, 1'b0);
    txn(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
    chk("raw_rdata", 0, rd, 16'h1234);
    chk("raw_err", 0, er, 1'b0);
    chk("rd_lat_ws0", 0, lat, 2);

    txn(1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
    chk("rd_lat_ws3", 1, lat, 5);
    chk("rd0_ws3", 1, rd, 16'hA5A5);

    txn(0, 1'b0, 16'h1000, 16'h0000, 1, 1'b0, 1'b0, rd, er, lat);
    chk("unmapped_err", 0, er, 1'b1);
    chk("unmapped_rdata", 0, rd, 16'h0000);
    txn(0, 1'b1, 16'h2000, 16'hDEAD, 0, 1'b0, 1'b0, rd, er, lat);
    chk("unmapped_wr_err", 0, er, 1'b1);
    txn(0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
    chk("rd0_unchanged", 0, rd, 16'hA5A5);
    txn(0, 1'b0, 16'h0FFF, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
    chk("top_word", 0, rd, 16'h7E57);

    txn(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b1, rd, er, lat);
    chk("early_ready_rdata", 0, rd, 16'h1234);
    chk("early_ready_lat", 0, lat, 2);

    txn(1, 1'b1, 16'h0010, 16'h4321, 0, 1'b0, 1'b0, rd, er, lat);
    txn(1, 1'b0, 16'h0010, 16'h0000, 4, 1'b1, 1'b0, rd, er, lat);
    chk("hold_rdata", 1, rd, 16'h4321);
    chk("hold_idle_ready", 1, req_ready[1], 1'b1);
    @(posedge clock); #1;
    chk("hold_second_accept", 1, req_ready[1], 1'b0);
    req_valid[1] = 1'b0;
    drain(1);

`ifdef MMIO_EN
    txn(0, 1'b1, 16'hFFF0, 16'h03FF, 0, 1'b0, 1'b0, rd, er, lat);
    chk("led_wr_err", 0, er, 1'b0);
    chk("led_lit", 0, led_out[0], 10'h3FF);
    @(negedge clock);
    sw_in = 10'h155;
    repeat (3) @(negedge clock);
    txn(0, 1'b0, 16'hFFF1, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
    chk("sw_rdata", 0, rd, 16'h0155);
    chk("sw_err", 0, er, 1'b0);
    txn(0, 1'b1, 16'hFFF1, 16'h0001, 0, 1'b0, 1'b0, rd, er, lat);
    chk("sw_wr_err", 0, er, 1'b1);
    txn(0, 1'b0, 16'hFFF0, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
    chk("led_rdata", 0, rd, 16'h03FF);
    txn(0, 1'b0, 16'hFF80, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
    chk("mmio_hole_err", 0, er, 1'b1);
`else
    txn(0, 1'b1, 16'hFFF0, 16'h03FF, 0, 1'b0, 1'b0, rd, er, lat);
    chk("led_addr_unmapped", 0, er, 1'b1);
    chk("led_tied_lit", 0, led_out[0], 10'd0);
    txn(0, 1'b0, 16'hFFF1, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
    chk("sw_addr_unmapped", 0, er, 1'b1);
    chk("sw_addr_rdata", 0, rd, 16'h0000);
`endif

    for (int d = 0; d < 2; d++) begin
      rst_in_access(d);
      txn(d, 1'b0, 16'h0005, 16'h0000, 0, 1'b0, 1'b0, rd, er, lat);
      chk("rst_no_commit", d, rd, 16'h0505);
    end

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        sel = $urandom_range(0, 9);
        if (sel <= 5)      a = 16'($urandom_range(0, 31));
        else if (sel == 6) a = 16'h0FFF;
        else if (sel == 7) a = 16'($urandom_range(16'h1000, 16'hFFFF));
        else if (sel == 8) a = ($urandom_range(0, 1) == 0) ? 16'hFFF0 : 16'hFFF1;
        else               a = 16'hFF00 + 16'($urandom_range(0, 255));
        w = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
          @(negedge clock);
          sw_in = 10'($urandom);
          repeat (3) @(negedge clock);
        end
        txn(d, w, a, 16'($urandom), $urandom_range(0, 3), 1'b0, ($urandom_range(0, 3) == 0),
            rd, er, lat);
        chk("rand_latency", d, lat, 2 + ws_of(d));
      end
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
